sram_sp_arbiter: RTL and testbench

// - Shares one single-port SRAM (1-cycle registered read, byte selects) among NPORTS requesters.
// - Accepts at most one access per cycle; tracks outstanding read/write; routes response to issuing port.
// - Supports locked bursts (port holds grant over consecutive beats, bounded by MAX_BURST).
// - Sits between core/NoC memory interfaces and the SRAM macro in a compute tile.

---
 rtl/sram_sp_arbiter_pkg.sv | 25 ++
 rtl/sram_sp_arbiter_rr.sv | 47 ++++
 rtl/sram_sp_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_sp_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sp_arbiter_pkg.sv
// Shared types and helpers for the single-port SRAM arbiter.
// Build option OPTIMSOC_SRAM_ARB_FIXED_PRIO_EN selects fixed-priority idle arbitration.
package optimsoc_sram_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for a given count; never returns less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sram_sp_arbiter_rr.sv
// One-hot grant from a request vector, round-robin from ptr by default.
// With OPTIMSOC_SRAM_ARB_FIXED_PRIO_EN the lowest requesting index wins and ptr is ignored.
module sram_arb_rr
    import optimsoc_sram_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int IW     = 1
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NPORTS-1:0] grant
);

`ifdef OPTIMSOC_SRAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!found && req[k]) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk ports starting at ptr, wrapping at NPORTS.
        for (int k = 0; k < NPORTS; k++) begin
            idx = IW'((int'(ptr) + k) % NPORTS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sram_sp_arbiter.sv
// Shares one single-port SRAM among NPORTS requesters with locked bursts.
// Build option OPTIMSOC_SRAM_ARB_FIXED_PRIO_EN switches idle arbitration to fixed priority.
module sram_sp_arbiter
    import optimsoc_sram_arb_pkg::*;
#(
    parameter int NPORTS    = 2,
    parameter int DW        = 32,
    parameter int WORD_AW   = 30,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          req_valid,
    input  logic [NPORTS-1:0]          req_we,
    input  logic [NPORTS-1:0]          req_lock,
    input  logic [NPORTS*WORD_AW-1:0]  req_addr,
    input  logic [NPORTS*DW-1:0]       req_data,
    input  logic [NPORTS*(DW/8)-1:0]   req_sel,
    output logic [NPORTS-1:0]          req_ready,
    output logic [NPORTS-1:0]          rsp_valid,
    output logic [DW-1:0]              rsp_data,
    output logic                       sram_ce,
    output logic                       sram_we,
    output logic                       sram_oe,
    output logic [WORD_AW-1:0]         sram_waddr,
    output logic [DW-1:0]              sram_din,
    output logic [DW/8-1:0]            sram_sel,
    input  logic [DW-1:0]              sram_dout
);

    localparam int SW = DW / 8;
    localparam int IW = clog2(NPORTS);
    localparam int CW = clog2(MAX_BURST + 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_valid_q, pend_valid_d;
    logic [IW-1:0] pend_port_q, pend_port_d;

    logic [NPORTS-1:0] rr_grant;
    logic [NPORTS-1:0] grant;
    logic [IW-1:0]     gnt_idx;
    logic              accept;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (int'(p) == NPORTS - 1) ? '0 : p + IW'(1);
    endfunction

    sram_arb_rr #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_q),
        .grant (rr_grant)
    );

    // A locked owner excludes everyone else, even while it has nothing to send.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (state_q == ARB_LOCKED) begin
                grant[owner_q] = req_valid[owner_q];
            end else begin
                grant = rr_grant;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (grant[k]) begin
                gnt_idx = IW'(k);
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    always_comb begin
        sram_ce    = accept;
        sram_we    = accept & req_we[gnt_idx];
        sram_oe    = accept & ~req_we[gnt_idx];
        sram_waddr = '0;
        sram_din   = '0;
        sram_sel   = '0;
        if (accept) begin
            sram_waddr = req_addr[int'(gnt_idx)*WORD_AW +: WORD_AW];
            sram_din   = req_data[int'(gnt_idx)*DW +: DW];
            sram_sel   = req_sel[int'(gnt_idx)*SW +: SW];
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        count_d      = count_q;
        pend_valid_d = accept;
        pend_port_d  = accept ? gnt_idx : pend_port_q;
        if (accept) begin
            if (state_q == ARB_IDLE) begin
                rr_d = wrap_inc(gnt_idx);
                if (req_lock[gnt_idx] && (MAX_BURST > 1)) begin
                    state_d = ARB_LOCKED;
                    owner_d = gnt_idx;
                    count_d = CW'(1);
                end
            end else begin
                // The beat that brings the count to MAX_BURST ends the burst.
                if (!req_lock[gnt_idx] || (count_q == CW'(MAX_BURST - 1))) begin
                    state_d = ARB_IDLE;
                    count_d = '0;
                    rr_d    = wrap_inc(owner_q);
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_q         <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_port_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
        end
    end

    // Masked by rst so a response pending when reset arrives is never seen.
    always_comb begin
        rsp_valid = '0;
        if (pend_valid_q && !rst) begin
            rsp_valid[pend_port_q] = 1'b1;
        end
    end

    assign rsp_data = sram_dout;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural SRAM and a rule-level arbitration model.
module tb_sram_sp_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int MB = 4;
    localparam int SW = DW / 8;
`ifdef OPTIMSOC_SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_data;
    logic [NP*SW-1:0]  req_sel;
    logic [DW-1:0]     rsp_data, sram_din, sram_dout;
    logic              sram_ce, sram_we, sram_oe;
    logic [AW-1:0]     sram_waddr;
    logic [SW-1:0]     sram_sel;

    int pass_cnt = 0;
    int total_cnt = 0;

    sram_sp_arbiter #(.NPORTS(NP), .DW(DW), .WORD_AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sram_ce(sram_ce), .sram_we(sram_we),
        .sram_oe(sram_oe), .sram_waddr(sram_waddr), .sram_din(sram_din), .sram_sel(sram_sel),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: registered read, byte-masked write.
    logic [DW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        sram_dout = '0;
        forever begin
            @(posedge clk);
            if (sram_ce) begin
                if (sram_we) begin
                    for (int b = 0; b < SW; b++)
                        if (sram_sel[b]) mem[sram_waddr[7:0]][b*8 +: 8] = sram_din[b*8 +: 8];
                end else begin
                    sram_dout = mem[sram_waddr[7:0]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else pass_cnt++;
    endtask

    // Model state: arbitration rules, shadow memory, expected responses {read, port, data}.
    logic [DW-1:0] shadow [256];
    logic [33:0]   exp_q[$];
    int            m_rr = 0;
    bit            m_locked = 1'b0;
    int            m_owner = 0;
    int            m_count = 0;

    function automatic int model_grant();
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NP; k++) begin
            int p;
            p = FIXED ? k : (m_rr + k) % NP;
            if (req_valid[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [33:0]   e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int            g;
        if (rst) begin
            exp_q.delete();
            m_locked = 1'b0; m_rr = 0; m_count = 0;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_ce", sram_ce, 0);
            return;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, 64'd1 << e[32]);
            if (e[33]) chk("rsp_data", rsp_data, e[31:0]);
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
        g = model_grant();
        chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g < 0) begin
            chk("ce_idle", {sram_ce, sram_we, sram_oe}, 0);
            chk("sel_idle", sram_sel, 0);
            return;
        end
        a = req_addr[g*AW +: AW];
        d = req_data[g*DW +: DW];
        s = req_sel[g*SW +: SW];
        chk("sram_ctl", {sram_ce, sram_we, sram_oe}, {1'b1, req_we[g], ~req_we[g]});
        chk("sram_addr", sram_waddr, a);
        chk("sram_sel", sram_sel, s);
        if (req_we[g]) begin
            chk("sram_din", sram_din, d);
            for (int b = 0; b < SW; b++) if (s[b]) shadow[a[7:0]][b*8 +: 8] = d[b*8 +: 8];
            exp_q.push_back({1'b0, g[0], 32'h0});
        end else begin
            exp_q.push_back({1'b1, g[0], shadow[a[7:0]]});
        end
        if (!m_locked) begin
            m_rr = (g + 1) % NP;
            if (req_lock[g] && MB > 1) begin
                m_locked = 1'b1; m_owner = g; m_count = 1;
            end
        end else begin
            m_count++;
            if (!req_lock[g] || m_count == MB) begin
                m_locked = 1'b0; m_rr = (m_owner + 1) % NP; m_count = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 32'hA500_0000 | i;
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // Driver tasks: inputs change only just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_data = '0; req_sel = '0;
    endtask

    task automatic set_port(input int p, input bit we, input bit lock, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_lock[p]  = lock;
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
        req_sel[p*SW +: SW]  = s;
    endtask

    int alt_exp [4];
    int lock_exp [7];
    int beat;

    initial begin
        for (int i = 0; i < 4; i++) alt_exp[i] = FIXED ? 1 : ((i % 2 == 0) ? 1 : 2);
        for (int i = 0; i < 7; i++) lock_exp[i] = FIXED ? 1 : ((i == 4) ? 1 : 2);
        clear_all();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_ce", sram_ce, 0);
        tick();

        set_port(0, 0, 0, 30'h1, 0, 4'hF);
        set_port(1, 0, 0, 30'h2, 0, 4'hF);
        @(negedge clk);
        chk("first_contention", req_ready, 2'b01);
        tick();

        clear_all();
        set_port(0, 1, 0, 30'h10, 32'hDEADBEEF, 4'hF);
        tick();
        set_port(0, 0, 0, 30'h10, 0, 4'hF);
        @(negedge clk);
        chk("p0_write_ack", rsp_valid, 2'b01);
        tick();
        clear_all();
        @(negedge clk);
        chk("p0_read_valid", rsp_valid, 2'b01);
        chk("p0_read_data", rsp_data, 32'hDEADBEEF);
        tick();

        set_port(1, 1, 0, 30'h10, 32'h0000AB00, 4'b0010);
        tick();
        set_port(1, 0, 0, 30'h10, 0, 4'hF);
        tick();
        clear_all();
        @(negedge clk);
        chk("p1_read_valid", rsp_valid, 2'b10);
        chk("p1_merge_data", rsp_data, 32'hDEADABEF);
        tick();

        for (int i = 0; i < 4; i++) begin
            set_port(0, 0, 0, 30'h20 + i, 0, 4'hF);
            set_port(1, 0, 0, 30'h30 + i, 0, 4'hF);
            @(negedge clk);
            chk("alternate_grant", req_ready, alt_exp[i]);
            tick();
        end
        clear_all();
        tick();

        set_port(0, 0, 0, 30'h50, 0, 4'hF);
        tick();
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            set_port(0, 0, 0, 30'h50, 0, 4'hF);
            set_port(1, 0, beat < 5, 30'h60 + beat, 0, 4'hF);
            @(negedge clk);
            chk("burst_grant", req_ready, lock_exp[c]);
            tick();
            if (lock_exp[c] == 2) beat++;
        end
        chk("burst_beats", beat, FIXED ? 0 : 6);
        clear_all();
        tick();

        set_port(0, 0, 1, 30'h70, 0, 4'hF);
        @(negedge clk);
        chk("lock_start", req_ready, 2'b01);
        tick();
        clear_all();
        set_port(1, 0, 0, 30'h71, 0, 4'hF);
        @(negedge clk);
        chk("owner_idle_hold", req_ready, 2'b00);
        tick();
        set_port(0, 0, 0, 30'h72, 0, 4'hF);
        @(negedge clk);
        chk("owner_unlock", req_ready, 2'b01);
        tick();
        clear_all();
        set_port(1, 0, 0, 30'h73, 0, 4'hF);
        @(negedge clk);
        chk("after_unlock", req_ready, 2'b10);
        tick();
        clear_all();
        tick();

        set_port(0, 0, 0, 30'h10, 0, 4'hF);
        @(negedge clk);
        chk("pre_reset_accept", req_ready, 2'b01);
        tick();
        clear_all();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_drops_rsp", rsp_valid, 2'b00);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp", rsp_valid, 2'b00);
        tick();
        set_port(0, 0, 0, 30'h3, 0, 4'hF);
        set_port(1, 0, 0, 30'h4, 0, 4'hF);
        @(negedge clk);
        chk("post_reset_contention", req_ready, 2'b01);
        tick();
        clear_all();
        tick();
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
